maxnet_frontend: RTL

MAXNET_FRONTEND -- requirements
Module: maxnet_frontend

---
 rtl/maxnet_pkg.sv | 22 ++
 rtl/Register.sv | 21 ++
 rtl/maxnet_frontend_ctrl.sv | 116 +++++++++++
 rtl/maxnet_frontend.sv | 73 +++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the maxnet competition front end.
package maxnet_pkg;

   localparam int unsigned DEFAULT_WIDTH   = 5;
   localparam int unsigned DEFAULT_TIMEOUT = 63;
   localparam int unsigned IDX_W           = 2;
   localparam int unsigned CNT_W           = 6;
   localparam int unsigned N_CAND          = 4;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESULT  = 2'd3
   } state_e;

   // One-hot select of the candidate slot addressed by the load index.
   function automatic logic [N_CAND-1:0] idx_decode(input logic [IDX_W-1:0] idx);
      return N_CAND'(1) << idx;
   endfunction

endpackage

// File: rtl/Register.sv
// Generic enabled register with asynchronous active-low clear.
module Register #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   // Load on enable, hold otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_q <= '0;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/maxnet_frontend_ctrl.sv
// Sequencer for the maxnet front end: candidate load index, run request,
// bounded wait for the datapath and result hold until it is consumed.
module maxnet_frontend_ctrl
   import maxnet_pkg::*;
#(
   parameter int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_in_valid,
   input  logic             i_done,
   input  logic [WIDTH-1:0] i_max_in,
   input  logic             i_res_ready,
   output logic             o_in_ready,
   output logic             o_hs_c,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_start,
   output logic             o_busy,
   output logic             o_res_valid,
   output logic [WIDTH-1:0] o_res_data,
   output logic             o_res_err
);

   state_e             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_count;
   logic               r_in_ready;
   logic               r_start;
   logic               r_busy;
   logic               r_res_valid;
   logic [WIDTH-1:0]   r_res_data;
   logic               r_res_err;

   logic               w_hs;
   logic               w_honour;
   logic               w_expired;

   // Accept handshake; done only counts once the datapath had a cycle to settle.
   assign w_hs      = i_in_valid & r_in_ready;
   assign w_honour  = i_done & (r_count != '0);
   assign w_expired = (r_count == CNT_W'(TIMEOUT));

   // State machine with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_COLLECT;
         r_idx       <= '0;
         r_count     <= '0;
         r_in_ready  <= 1'b1;
         r_start     <= 1'b0;
         r_busy      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_COLLECT: begin
               if (w_hs) begin
                  if (r_idx == IDX_W'(N_CAND - 1)) begin
                     r_idx      <= '0;
                     r_state    <= ST_START;
                     r_start    <= 1'b1;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b1;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            ST_START: begin
               r_start <= 1'b0;
               r_count <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_honour) begin
                  r_res_data  <= i_max_in;
                  r_res_err   <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_RESULT;
               end else if (w_expired) begin
                  r_res_data  <= '0;
                  r_res_err   <= 1'b1;
                  r_res_valid <= 1'b1;
                  r_state     <= ST_RESULT;
               end else begin
                  r_count <= r_count + CNT_W'(1);
               end
            end
            ST_RESULT: begin
               if (i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_idx       <= '0;
                  r_state     <= ST_COLLECT;
               end
            end
            default: begin
               r_state <= ST_COLLECT;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_hs_c      = w_hs;
   assign o_idx       = r_idx;
   assign o_start     = r_start;
   assign o_busy      = r_busy;
   assign o_res_valid = r_res_valid;
   assign o_res_data  = r_res_data;
   assign o_res_err   = r_res_err;

endmodule

// File: rtl/maxnet_frontend.sv
// Front end for the maxnet competition datapath: collects four candidates,
// launches a run and returns the winner (or a timeout error).
module maxnet_frontend
   import maxnet_pkg::*;
#(
   parameter int unsigned WIDTH   = DEFAULT_WIDTH,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] X1,
   output logic [WIDTH-1:0] X2,
   output logic [WIDTH-1:0] X3,
   output logic [WIDTH-1:0] X4,
   output logic             start,
   input  logic             done,
   input  logic [WIDTH-1:0] max_in,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_err,
   output logic             busy
);

   logic                w_hs;
   logic [IDX_W-1:0]    w_idx;
   logic [N_CAND-1:0]   w_wen;
   logic [WIDTH-1:0]    w_x [N_CAND];

   maxnet_frontend_ctrl #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (in_valid),
      .i_done      (done),
      .i_max_in    (max_in),
      .i_res_ready (res_ready),
      .o_in_ready  (in_ready),
      .o_hs_c      (w_hs),
      .o_idx       (w_idx),
      .o_start     (start),
      .o_busy      (busy),
      .o_res_valid (res_valid),
      .o_res_data  (res_data),
      .o_res_err   (res_err)
   );

   // Only the slot addressed by the load index captures, and only on a handshake.
   assign w_wen = idx_decode(w_idx) & {N_CAND{w_hs}};

   for (genvar g = 0; g < N_CAND; g++) begin : g_cand
      Register #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk  (clk),
         .rst  (rst),
         .i_en (w_wen[g]),
         .i_d  (in_data),
         .o_q  (w_x[g])
      );
   end

   assign X1 = w_x[0];
   assign X2 = w_x[1];
   assign X3 = w_x[2];
   assign X4 = w_x[3];

endmodule
